// File: rtl/serial_addsub_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives the operands and start; the slave returns the result and status.
interface serial_addsub_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic         mode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, mode, a, b,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, mode, a, b,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one full adder, LSB first, one bit per clock.
// Results are loaded only on the completing edge and held until the next completion.
module serial_addsub #(
  parameter int unsigned N = 4
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBit = CW'(N - 1);
  localparam logic [CW-1:0] PreLast = CW'(N - 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_sh, b_sh;
  logic [N-2:0]  res_sh;
  logic [CW-1:0] cnt_q;
  logic          mode_q, carry_q, cmsb_q;
  logic [N-1:0]  sum_q;
  logic          cout_q, ovf_q;

  logic          bx, fa_s, fa_c, last;
  logic [N-1:0]  res_d;

  assign last  = (cnt_q == LastBit);
  assign bx    = b_sh[0] ^ mode_q;
  assign fa_s  = a_sh[0] ^ bx ^ carry_q;
  assign fa_c  = (a_sh[0] & bx) | (a_sh[0] & carry_q) | (bx & carry_q);
  assign res_d = {fa_s, res_sh};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            mode_q  <= bus.mode;
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= bus.mode;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_d[N-1:1];
          carry_q <= fa_c;
          // Carry out of bit N-2 is the carry into the MSB, needed for overflow.
          if (cnt_q == PreLast) cmsb_q <= fa_c;
          if (last) begin
            sum_q  <= res_d;
            cout_q <= fa_c;
            ovf_q  <= ((N == 2) ? carry_q : cmsb_q) ^ fa_c;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (N=4) with hand-computed expected results.
module tb_serial_addsub;
  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_addsub_if #(.N(N)) bus ();

  serial_addsub #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse (bounded).
  task automatic do_op(input logic m, input logic [N-1:0] av, input logic [N-1:0] bv,
                       output int edges, output int busy_cyc, output bit got_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges = 0;
    busy_cyc = 0;
    got_done = 1'b0;
    @(negedge clk);
    if (bus.busy) busy_cyc++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic op_check(input string tag, input logic m, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input logic [N-1:0] es, input logic ec,
                          input logic eo);
    int  e, bc;
    bit  gd;
    do_op(m, av, bv, e, bc, gd);
    check_eq({tag, " done"}, 32'(gd), 32'd1);
    check_eq({tag, " sum"}, 32'(bus.sum), 32'(es));
    check_eq({tag, " cout"}, 32'(bus.cout), 32'(ec));
    check_eq({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
  endtask

  initial begin
    int  e, bc, last_done, pulses;
    bit  gd, seen_done, sum_held;
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst sum", 32'(bus.sum), 32'd0);
    check_eq("rst cout", 32'(bus.cout), 32'd0);
    check_eq("rst ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    // Basic add with latency, busy width and single-cycle done.
    do_op(1'b0, 4'b0110, 4'b1000, e, bc, gd);
    check_eq("add done", 32'(gd), 32'd1);
    check_eq("add latency", 32'(e), 32'd4);
    check_eq("add busy cycles", 32'(bc), 32'd4);
    check_eq("add sum", 32'(bus.sum), 32'b1110);
    check_eq("add cout", 32'(bus.cout), 32'd0);
    check_eq("add ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    check_eq("done one cycle", 32'(bus.done), 32'd0);
    check_eq("sum held", 32'(bus.sum), 32'b1110);

    op_check("sub 2-6", 1'b1, 4'b0010, 4'b0110, 4'b1100, 1'b0, 1'b0);
    op_check("sub 5-3", 1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    op_check("add ovf", 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    op_check("sub ovf", 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);
    op_check("add carry", 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);

    // Restart attempt mid-operation with changed operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.a = 4'b0011; bus.b = 4'b0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 begin
      bus.start = 1'b1; bus.mode = 1'b1; bus.a = 4'b1111; bus.b = 4'b1111;
    end
    @(negedge clk);
    sum_held = (bus.sum === 4'b0000);
    bus.start = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        gd = 1'b1;
        break;
      end
      if (bus.sum !== 4'b0000) sum_held = 1'b0;
    end
    check_eq("restart done", 32'(gd), 32'd1);
    check_eq("restart sum unchanged", 32'(sum_held), 32'd1);
    check_eq("restart sum", 32'(bus.sum), 32'b0100);
    check_eq("restart cout", 32'(bus.cout), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("restart idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset two edges into an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.a = 4'b0101; bus.b = 4'b0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort sum", 32'(bus.sum), 32'd0);
    check_eq("abort cout", 32'(bus.cout), 32'd0);
    check_eq("abort busy", 32'(bus.busy), 32'd0);
    seen_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check_eq("abort no done", 32'(seen_done), 32'd0);
    do_op(1'b0, 4'b0011, 4'b0001, e, bc, gd);
    check_eq("post rst latency", 32'(e), 32'd4);
    check_eq("post rst sum", 32'(bus.sum), 32'b0100);

    // Start held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.a = 4'b0001; bus.b = 4'b0001;
    last_done = -1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        check_eq("b2b sum", 32'(bus.sum), 32'b0010);
        if (last_done >= 0) check_eq("b2b period", 32'(i - last_done), 32'd6);
        last_done = i;
        pulses++;
      end
    end
    bus.start = 1'b0;
    check_eq("b2b pulses", 32'(pulses >= 4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
